// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration master: responder register
// map, per-profile write tables and the sequencer state encoding.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;
    localparam logic [5:0] ADDR_MFRAC  = 6'h07;

    localparam logic [31:0] MODE_POLL = 32'h0000_0001;
    localparam logic [31:0] START_GO  = 32'h0000_0001;

    localparam int unsigned TABLE_LEN = 7;
    localparam logic [2:0]  LAST_IDX  = 3'(TABLE_LEN - 1);

    // Profile 0: 50 MHz ref, N bypassed, M = 11 + frac -> VCO ~572.727 MHz,
    // C0 = 40 -> 14.318180 MHz, C1 = 10 -> 57.272720 MHz.
    localparam logic [31:0] P0_N     = 32'h0001_0000;
    localparam logic [31:0] P0_M     = 32'h0000_0605;
    localparam logic [31:0] P0_C0    = 32'h0000_1414;
    localparam logic [31:0] P0_C1    = 32'h0004_0505;
    localparam logic [31:0] P0_MFRAC = 32'h745C_FEDE;

    // Profile 1: N = 2, M = 24 -> VCO 600 MHz, C0 = 20 (30 MHz), C1 = 8 (75 MHz).
    localparam logic [31:0] P1_N     = 32'h0000_0101;
    localparam logic [31:0] P1_M     = 32'h0000_0C0C;
    localparam logic [31:0] P1_C0    = 32'h0000_0A0A;
    localparam logic [31:0] P1_C1    = 32'h0004_0404;
    localparam logic [31:0] P1_MFRAC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK0,
        ST_WRITE,
        ST_STATUS_RD,
        ST_WAIT_LOCK1,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_entry_t;

    // Any profile index other than 0 selects the alternate timing.
    function automatic wr_entry_t table_entry(input int unsigned prof, input logic [2:0] idx);
        wr_entry_t e;
        logic      p0;
        p0 = (prof == 0);
        e  = '{addr: ADDR_MODE, data: '0};
        case (idx)
            3'd0: e = '{addr: ADDR_MODE,  data: MODE_POLL};
            3'd1: e = '{addr: ADDR_N,     data: p0 ? P0_N     : P1_N};
            3'd2: e = '{addr: ADDR_M,     data: p0 ? P0_M     : P1_M};
            3'd3: e = '{addr: ADDR_C,     data: p0 ? P0_C0    : P1_C0};
            3'd4: e = '{addr: ADDR_C,     data: p0 ? P0_C1    : P1_C1};
            3'd5: e = '{addr: ADDR_MFRAC, data: p0 ? P0_MFRAC : P1_MFRAC};
            3'd6: e = '{addr: ADDR_START, data: START_GO};
            default: e = '{addr: ADDR_MODE, data: '0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_reconfig_master.sv
// Avalon-MM master that walks a PLL reconfiguration table, polls for
// completion and waits for lock, with a shared lock/poll timeout.
module pll_reconfig_master
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned NUM_PROFILES = 2
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic                            cfg_req,
    input  logic [$clog2(NUM_PROFILES)-1:0] cfg_sel,
    input  logic                            pll_locked,
    output logic [5:0]                      mgmt_address,
    output logic                            mgmt_write,
    output logic                            mgmt_read,
    output logic [31:0]                     mgmt_writedata,
    input  logic [31:0]                     mgmt_readdata,
    input  logic                            mgmt_waitrequest,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SEL_W = $clog2(NUM_PROFILES);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   prof_q, prof_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               lock_s;
    wr_entry_t          first_e, next_e;
    logic               unused_readdata;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    assign unused_readdata = ^mgmt_readdata[31:1];
    assign first_e = table_entry(int'(prof_q), 3'd0);
    assign next_e  = table_entry(int'(prof_q), idx_q + 3'd1);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            prof_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            prof_q  <= prof_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        prof_d  = prof_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    prof_d  = cfg_sel;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK0;
                end
            end
            ST_WAIT_LOCK0: begin
                if (lock_s) begin
                    idx_d   = '0;
                    addr_d  = first_e.addr;
                    wdata_d = first_e.data;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_WRITE: begin
                // Strobe stays high across entries: each completion loads the next pair.
                if (!mgmt_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        rd_d    = 1'b1;
                        addr_d  = ADDR_STATUS;
                        cnt_d   = '0;
                        state_d = ST_STATUS_RD;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        addr_d  = next_e.addr;
                        wdata_d = next_e.data;
                    end
                end
            end
            ST_STATUS_RD: begin
                if (!mgmt_waitrequest && mgmt_readdata[0]) begin
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
                        rd_d    = 1'b0;
                        addr_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_WAIT_LOCK1: begin
                if (lock_s) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = !err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign mgmt_write     = wr_q;
    assign mgmt_read      = rd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Directed bench for pll_reconfig_master with an Avalon-MM responder model.
module tb_pll_reconfig_master;
    import pll_reconfig_pkg::*;

    localparam int unsigned LT = 100;

    logic        refclk = 1'b0;
    logic        rst, cfg_req, pll_locked;
    logic [0:0]  cfg_sel;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] readdata = '0;
    logic        waitreq = 1'b0;
    logic        busy, done, error;

    always #5 refclk = ~refclk;

    pll_reconfig_master #(.LOCK_TIMEOUT(LT), .NUM_PROFILES(2)) dut (
        .refclk           (refclk),
        .rst              (rst),
        .cfg_req          (cfg_req),
        .cfg_sel          (cfg_sel),
        .pll_locked       (pll_locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (readdata),
        .mgmt_waitrequest (waitreq),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    logic [5:0]  exp_addr [7] = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h07, 6'h02};
    logic [31:0] exp_data [2][7] = '{
        '{32'h1, 32'h0001_0000, 32'h0000_0605, 32'h0000_1414, 32'h0004_0505, 32'h745C_FEDE, 32'h1},
        '{32'h1, 32'h0000_0101, 32'h0000_0C0C, 32'h0000_0A0A, 32'h0004_0404, 32'h0000_0000, 32'h1}
    };

    int checks = 0;
    int failures = 0;

    // Responder configuration (main process) and private state (responder).
    int stall_addr = -1, stall_len = 0, poll_zeros = 0, scen = 0;
    int r_scen = 0, stall_cnt = 0, polls_done = 0;
    bit stall_used = 0;
    logic        s_wr = 1'b0, s_rd = 1'b0;
    logic [5:0]  s_addr = '0;
    logic [31:0] s_data = '0;

    logic [5:0]  log_addr [512];
    logic [31:0] log_data [512];
    int wr_n = 0, rd_n = 0, both_n = 0, wr_cyc = 0;

    always @(negedge refclk) begin
        if (r_scen != scen) begin
            r_scen = scen; stall_cnt = 0; stall_used = 0; polls_done = 0;
        end
        waitreq = 1'b0;
        if (mgmt_write && !stall_used && int'(mgmt_address) == stall_addr) begin
            if (stall_cnt < stall_len) begin
                waitreq = 1'b1; stall_cnt++;
            end else begin
                stall_used = 1;
            end
        end
        readdata = 32'hFFFF_FFFE;
        if (mgmt_read && !waitreq) begin
            readdata[0] = (polls_done >= poll_zeros);
            polls_done++;
        end
        s_wr = mgmt_write; s_rd = mgmt_read; s_addr = mgmt_address; s_data = mgmt_writedata;
    end

    always @(posedge refclk) begin
        if (!rst) begin
            if (s_wr && s_rd) both_n++;
            if (s_wr) wr_cyc++;
            if (s_wr && !waitreq) begin
                if (wr_n < 512) begin
                    log_addr[wr_n] = s_addr; log_data[wr_n] = s_data;
                end
                wr_n++;
            end
            if (s_rd && !waitreq) rd_n++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input int base, input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("s%0d_wr%0d_addr", sel, i), 32'(log_addr[base + i]), 32'(exp_addr[i]));
            check($sformatf("s%0d_wr%0d_data", sel, i), log_data[base + i], exp_data[sel][i]);
        end
    endtask

    task automatic pulse_req(input int sel);
        @(negedge refclk);
        cfg_sel = 1'(sel);
        cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
    endtask

    task automatic run_seq(input int sel, output int m_hold, output int cycles);
        bit timed_out;
        m_hold = 0; cycles = -1; timed_out = 1;
        pulse_req(sel);
        for (int c = 0; c < 3000; c++) begin
            @(negedge refclk);
            if (mgmt_write && mgmt_address == 6'h04 && mgmt_writedata == exp_data[sel][2]) m_hold++;
            if (!busy) begin
                timed_out = 0; cycles = c; break;
            end
        end
        check("seq_bounded", 32'(timed_out), 32'd0);
    endtask

    typedef struct {
        int sel; int st_addr; int st_len; int pz;
        int e_done; int e_err; int e_reads; int e_mhold;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int w0, r0, c0, mh, cyc, found;

        vecs[0] = '{0, -1, 0, 0,    1, 0, 1,  1};
        vecs[1] = '{1, -1, 0, 3,    1, 0, 4,  1};
        vecs[2] = '{0,  4, 3, 0,    1, 0, 1,  4};
        vecs[3] = '{1,  5, 2, 1,    1, 0, 2,  1};
        vecs[4] = '{0,  2, 5, 2,    1, 0, 3,  1};
        vecs[5] = '{1, -1, 0, 1000, 0, 1, -1, 1};

        rst = 1'b1; cfg_req = 1'b0; cfg_sel = '0; pll_locked = 1'b1;
        repeat (3) @(negedge refclk);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_write", 32'(mgmt_write), 0);
        check("rst_read",  32'(mgmt_read), 0);
        check("rst_addr",  32'(mgmt_address), 0);
        check("rst_wdata", mgmt_writedata, 0);
        rst = 1'b0;
        repeat (2) @(negedge refclk);

        for (int v = 0; v < 6; v++) begin
            scen++;
            stall_addr = vecs[v].st_addr; stall_len = vecs[v].st_len; poll_zeros = vecs[v].pz;
            w0 = wr_n; r0 = rd_n;
            run_seq(vecs[v].sel, mh, cyc);
            check($sformatf("v%0d_done", v),  32'(done),  32'(vecs[v].e_done));
            check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].e_err));
            check($sformatf("v%0d_nwr", v),   32'(wr_n - w0), 32'd7);
            if (wr_n - w0 == 7) check_writes(w0, vecs[v].sel, 7);
            if (vecs[v].e_reads >= 0) check($sformatf("v%0d_reads", v), 32'(rd_n - r0), 32'(vecs[v].e_reads));
            check($sformatf("v%0d_m_hold", v), 32'(mh), 32'(vecs[v].e_mhold));
        end

        // Lock never arrives: timeout after exactly LT waiting cycles, no writes.
        scen++; stall_addr = -1; poll_zeros = 0;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        c0 = wr_cyc;
        run_seq(0, mh, cyc);
        check("to_error", 32'(error), 1);
        check("to_done",  32'(done), 0);
        check("to_write_cycles", 32'(wr_cyc - c0), 0);
        check("to_cycles", 32'(cyc), LT);
        pll_locked = 1'b1;
        repeat (3) @(negedge refclk);

        // Extra requests while busy are ignored.
        scen++; w0 = wr_n;
        pulse_req(0);
        found = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge refclk);
            cfg_req = (c == 2 || c == 6);
            cfg_sel = 1'b1;
            if (!busy && !cfg_req) begin found = 1; break; end
        end
        cfg_req = 1'b0;
        check("busyreq_bounded", 32'(found), 1);
        repeat (10) @(negedge refclk);
        check("busyreq_idle", 32'(busy), 0);
        check("busyreq_done", 32'(done), 1);
        check("busyreq_nwr", 32'(wr_n - w0), 7);
        if (wr_n - w0 == 7) check_writes(w0, 0, 7);

        // Reset while the C0 write is on the bus.
        scen++; w0 = wr_n;
        pulse_req(0);
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge refclk);
            if (mgmt_write && mgmt_address == 6'h05) begin found = 1; break; end
        end
        check("rst_c0_seen", 32'(found), 1);
        check("rst_c0_data", mgmt_writedata, exp_data[0][3]);
        rst = 1'b1;
        @(negedge refclk);
        check("rst_mid_write", 32'(mgmt_write), 0);
        check("rst_mid_busy",  32'(busy), 0);
        check("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        check("rst_mid_nwr", 32'(wr_n - w0), 3);
        @(negedge refclk);
        scen++; w0 = wr_n;
        run_seq(1, mh, cyc);
        check("rst_restart_done", 32'(done), 1);
        check("rst_restart_nwr", 32'(wr_n - w0), 7);
        if (wr_n - w0 == 7) check_writes(w0, 1, 7);

        // Lock drops at the start write and returns 50 cycles later.
        scen++; poll_zeros = 0;
        pulse_req(0);
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge refclk);
            if (mgmt_write && mgmt_address == 6'h02) begin found = 1; break; end
        end
        check("lk_start_seen", 32'(found), 1);
        pll_locked = 1'b0;
        repeat (50) @(negedge refclk);
        check("lk_wait_busy", 32'(busy), 1);
        check("lk_wait_done", 32'(done), 0);
        pll_locked = 1'b1;
        repeat (3) @(negedge refclk);
        check("lk_sync_done", 32'(done), 0);
        check("lk_sync_busy", 32'(busy), 1);
        @(negedge refclk);
        check("lk_final_done", 32'(done), 1);
        check("lk_final_busy", 32'(busy), 0);
        check("lk_final_err",  32'(error), 0);

        check("rd_wr_overlap", 32'(both_n), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_master.md
PLL_RECONFIG_MASTER -- requirements
Module: pll_reconfig_master

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1000000, maximum refclk cycles to wait for pll_locked before flagging an error.
REQ-002 SHALL have parameter NUM_PROFILES, default 2, number of selectable PLL output-frequency profiles.
REQ-003 SHALL have port refclk  input  1  the single clock (50 MHz management clock); all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port cfg_req  input  1  one-cycle pulse requesting reconfiguration.
REQ-006 SHALL have port cfg_sel  input  $clog2(NUM_PROFILES)  profile index, sampled on an accepted cfg_req.
REQ-007 SHALL have port pll_locked  input  1  PLL lock indicator; asynchronous to refclk.
REQ-008 SHALL have port mgmt_address  output  6  Avalon-MM word address to the PLL reconfig responder.
REQ-009 SHALL have port mgmt_write / mgmt_read  output  1 each  Avalon-MM write and read strobes.
REQ-010 SHALL have port mgmt_writedata  output  32  write data.
REQ-011 SHALL have port mgmt_readdata  input  32  read data, valid in the cycle a read completes.
REQ-012 SHALL have port mgmt_waitrequest  input  1  responder stall.
REQ-013 SHALL have ports busy, done, error  output  1 each  status: sequence running / last sequence succeeded / last sequence timed out.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer before any use.
REQ-015 SHALL implement states IDLE, WAIT_LOCK0, WRITE, STATUS_RD, WAIT_LOCK1, FINISH.
REQ-016 IDLE: a cfg_req pulse SHALL latch cfg_sel, clear done and error, assert busy, and go to WAIT_LOCK0 the next cycle; cfg_req outside IDLE SHALL be ignored.
REQ-017 WAIT_LOCK0 and WAIT_LOCK1: SHALL advance once synced lock is 1; otherwise SHALL increment a timeout counter and go to FINISH with error=1 when it reaches LOCK_TIMEOUT.
REQ-018 WRITE: SHALL issue, in table order, the profile's (address,data) pairs: mode reg 0x00=1 (polling), N 0x03, M 0x04, C0 0x05, C1 0x05, M-fraction 0x07, then start reg 0x02=1.
REQ-019 Each Avalon transfer SHALL hold address, data and strobe stable while mgmt_waitrequest=1 and SHALL complete in the first cycle with strobe=1 and waitrequest=0; the next transfer SHALL start no earlier than the following cycle.
REQ-020 STATUS_RD: SHALL read address 0x01 repeatedly until mgmt_readdata[0]=1, then go to WAIT_LOCK1; the poll loop SHALL share the LOCK_TIMEOUT counter, which reloads to 0 on entry to each wait state.
REQ-021 FINISH: SHALL drop busy, set done=1 if no error, and return to IDLE in one cycle; done and error SHALL hold until the next accepted cfg_req.
REQ-022 mgmt_read and mgmt_write SHALL never be asserted in the same cycle.
REQ-023 Table index SHALL use a 3-bit counter; wrap past the last entry SHALL not occur (the transition to STATUS_RD SHALL take place instead).

Reset
REQ-024 While rst=1 the block SHALL enter IDLE, and busy, done, error, mgmt_read and mgmt_write SHALL be 0, mgmt_address 0, mgmt_writedata 0, counters 0, and synchronizer flops 0.
REQ-025 rst asserted mid-transfer SHALL drop strobes the following cycle without completing the transfer; no pending cfg_req is remembered.

Structure
REQ-026 A shared package pll_reconfig_pkg SHALL hold register address constants, the per-profile write table (profile 0: 14.318180/57.272720 MHz; profile 1: alternate timing) and the state enum.
REQ-027 The lock synchronizer SHALL be a separate sub-module named sync_2ff.

Verification
REQ-028 Locked=1, cfg_req with cfg_sel=0, waitrequest=0 -> 7 writes at addresses 00,03,04,05,05,07,02 in consecutive transfers, status reads until readdata[0]=1, done=1, busy=0.
REQ-029 waitrequest held 3 cycles on the M write -> address and data stable for 4 cycles, exactly one write at 0x04 counted.
REQ-030 pll_locked=0 throughout with LOCK_TIMEOUT=100 -> error=1, done=0, no mgmt_write ever asserted.
REQ-031 cfg_req pulsed again while busy -> ignored, one sequence only, table entries from first cfg_sel.
REQ-032 rst asserted during the C0 write -> next cycle mgmt_write=0, busy=0, state IDLE; a new cfg_req restarts from address 0x00.
REQ-033 pll_locked drops after start and returns 50 cycles later -> done=1 only after the synced lock returns (latency 2 cycles).
